// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: tick-paced player sprite position (saturating) plus autonomous sprite (wrap or bounce)
// Ports: clk, rst (async active-low); run pauses everything; left/right/up/down key levels;
// pos_h/pos_v player coordinates; npc_h/npc_v autonomous sprite coordinates;
// moved pulses when a tick changed the player coordinate; npc_dir is the bounce direction (1 = -h).
module sprite_motion_ctrl #(
  parameter int W        = 10,
  parameter int H_MIN    = 20,
  parameter int H_MAX    = 319,
  parameter int V_MIN    = 20,
  parameter int V_MAX    = 239,
  parameter int STEP     = 1,
  parameter int NPC_STEP = 1,
  parameter int TICK_DIV = 1,
  parameter int DIAG_EN  = 0,
  parameter int NPC_MODE = 0,
  parameter int H0       = 20,
  parameter int V0       = 20,
  parameter int NPC_V    = 120
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         left,
  input  logic         right,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] pos_h,
  output logic [W-1:0] pos_v,
  output logic [W-1:0] npc_h,
  output logic [W-1:0] npc_v,
  output logic         moved,
  output logic         npc_dir
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
  localparam logic [W:0] HMN = (W+1)'(H_MIN);
  localparam logic [W:0] HMX = (W+1)'(H_MAX);
  localparam logic [W:0] VMN = (W+1)'(V_MIN);
  localparam logic [W:0] VMX = (W+1)'(V_MAX);
  localparam logic [W:0] S   = (W+1)'(STEP);
  localparam logic [W:0] NS  = (W+1)'(NPC_STEP);
  typedef enum logic {FWD, REV} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic tick, go_l, go_r, go_u, go_d;
  logic [W:0] ph, pv, nh;
  logic [W-1:0] h_nx, v_nx, npc_nx;
  assign tick  = run && cnt == CMAX;
  assign npc_v = W'(NPC_V);
  // Player next position; all bound tests in W+1 bits so add/subtract never wraps
  always_comb begin
    ph   = {1'b0, pos_h};
    pv   = {1'b0, pos_v};
    go_l = DIAG_EN != 0 ? left && !right : left;
    go_r = right && !left;
    go_u = DIAG_EN != 0 ? up && !down : up && !left && !right;
    go_d = DIAG_EN != 0 ? down && !up : down && !up && !left && !right;
    h_nx = go_l ? (ph < HMN + S ? W'(H_MIN) : pos_h - W'(STEP)) :
           go_r ? (ph + S > HMX ? W'(H_MAX) : pos_h + W'(STEP)) : pos_h;
    v_nx = go_u ? (pv < VMN + S ? W'(V_MIN) : pos_v - W'(STEP)) :
           go_d ? (pv + S > VMX ? W'(V_MAX) : pos_v + W'(STEP)) : pos_v;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt   <= '0;
      pos_h <= W'(H0);
      pos_v <= W'(V0);
      moved <= 1'b0;
    end else if (run) begin
      cnt   <= tick ? '0 : cnt + CW'(1);
      moved <= tick && (h_nx != pos_h || v_nx != pos_v);
      if (tick) begin
        pos_h <= h_nx;
        pos_v <= v_nx;
      end
    end else begin
      moved <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FWD;
      npc_h <= W'(H_MIN);
    end else if (tick) begin
      state <= state_nx;
      npc_h <= npc_nx;
    end
  // Bounce: the endpoint is emitted on the turning tick, so it is held for one tick
  always_comb begin
    nh       = {1'b0, npc_h};
    state_nx = state;
    npc_nx   = nh + NS > HMX ? W'(H_MIN) : npc_h + W'(NPC_STEP);
    if (NPC_MODE != 0) begin
      state_nx = state == FWD ? (nh + NS >= HMX ? REV : FWD) : (nh <= HMN + NS ? FWD : REV);
      npc_nx   = state == FWD ? (nh + NS >= HMX ? W'(H_MAX) : npc_h + W'(NPC_STEP)) :
                                (nh <= HMN + NS ? W'(H_MIN) : npc_h - W'(NPC_STEP));
    end
  end
  always_comb npc_dir = state == REV;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: three configurations driven together and checked against an arithmetic model
module tb_sprite_motion_ctrl;
  logic clk = 0, rst = 0, run = 0, left = 0, right = 0, up = 0, down = 0;
  logic [9:0] pos_h[3], pos_v[3], npc_h[3], npc_v[3];
  logic moved[3], npc_dir[3];
  int checks = 0, failures = 0;
  int td[3] = '{1, 1, 4};
  int st[3] = '{1, 1, 3};
  int dg[3] = '{0, 1, 1};
  int nm[3] = '{0, 1, 0};
  int ns[3] = '{100, 100, 1};
  int mh[3], mv[3], mn[3], md[3], mc[3], mm[3];
  int s_wrap[8]   = '{20, 120, 220, 20, 120, 220, 20, 120};
  int s_bounce[8] = '{20, 120, 220, 319, 219, 119, 20, 120};
  int s_dir[8]    = '{0, 0, 0, 1, 1, 1, 0, 0};

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.NPC_STEP(100)) u0 (
    .clk(clk), .rst(rst), .run(run), .left(left), .right(right), .up(up), .down(down),
    .pos_h(pos_h[0]), .pos_v(pos_v[0]), .npc_h(npc_h[0]), .npc_v(npc_v[0]),
    .moved(moved[0]), .npc_dir(npc_dir[0]));
  sprite_motion_ctrl #(.NPC_STEP(100), .DIAG_EN(1), .NPC_MODE(1)) u1 (
    .clk(clk), .rst(rst), .run(run), .left(left), .right(right), .up(up), .down(down),
    .pos_h(pos_h[1]), .pos_v(pos_v[1]), .npc_h(npc_h[1]), .npc_v(npc_v[1]),
    .moved(moved[1]), .npc_dir(npc_dir[1]));
  sprite_motion_ctrl #(.TICK_DIV(4), .STEP(3), .DIAG_EN(1)) u2 (
    .clk(clk), .rst(rst), .run(run), .left(left), .right(right), .up(up), .down(down),
    .pos_h(pos_h[2]), .pos_v(pos_v[2]), .npc_h(npc_h[2]), .npc_v(npc_v[2]),
    .moved(moved[2]), .npc_dir(npc_dir[2]));

  function automatic int clamp(int v, int lo, int hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction

  task automatic chk(string tag, int i, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      mh[i] = 20; mv[i] = 20; mn[i] = 20; md[i] = 0; mc[i] = 0; mm[i] = 0;
    end
  endtask

  task automatic mstep();
    int dx, dy, nh, nv;
    for (int i = 0; i < 3; i++) begin
      mm[i] = 0;
      if (!run) continue;
      if (mc[i] != td[i] - 1) begin
        mc[i]++;
        continue;
      end
      mc[i] = 0;
      if (dg[i] != 0) begin
        dx = int'(right) - int'(left);
        dy = int'(down) - int'(up);
      end else begin
        dx = left ? -1 : right ? 1 : 0;
        dy = (left || right) ? 0 : up ? -1 : down ? 1 : 0;
      end
      nh = clamp(mh[i] + dx * st[i], 20, 319);
      nv = clamp(mv[i] + dy * st[i], 20, 239);
      mm[i] = (nh != mh[i] || nv != mv[i]) ? 1 : 0;
      mh[i] = nh;
      mv[i] = nv;
      if (nm[i] == 0) mn[i] = mn[i] + ns[i] > 319 ? 20 : mn[i] + ns[i];
      else if (md[i] == 0) begin
        if (mn[i] + ns[i] >= 319) begin mn[i] = 319; md[i] = 1; end
        else mn[i] += ns[i];
      end else begin
        if (mn[i] - ns[i] <= 20) begin mn[i] = 20; md[i] = 0; end
        else mn[i] -= ns[i];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("pos_h", i, int'(pos_h[i]), mh[i]);
      chk("pos_v", i, int'(pos_v[i]), mv[i]);
      chk("npc_h", i, int'(npc_h[i]), mn[i]);
      chk("npc_v", i, int'(npc_v[i]), 120);
      chk("moved", i, int'(moved[i]), mm[i]);
      chk("npc_dir", i, int'(npc_dir[i]), md[i]);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) mstep();
      #1;
      check_all();
    end
  endtask

  task automatic pulse_reset();
    #3 rst = 0;
    mreset();
    #1 check_all();
    #2 rst = 1;
  endtask

  task automatic rand_keys();
    {left, right, up, down} = 4'($urandom);
  endtask

  initial begin
    mreset();
    #12 check_all();
    chk("rst_pos_h", 0, int'(pos_h[0]), 20);
    @(negedge clk);
    rst = 1; run = 1; left = 1;
    cyc(5);
    chk("left_sat_h", 0, int'(pos_h[0]), 20);
    chk("left_sat_moved", 0, int'(moved[0]), 0);
    left = 0; right = 1;
    cyc(3);
    chk("right_h", 0, int'(pos_h[0]), 23);
    chk("right_moved", 0, int'(moved[0]), 1);
    right = 0; left = 1; down = 1;
    cyc(1);
    chk("prio_v", 0, int'(pos_v[0]), 20);
    chk("prio_h", 0, int'(pos_h[0]), 22);
    left = 0; down = 0;
    pulse_reset();
    right = 1; down = 1;
    cyc(1);
    chk("diag_h", 1, int'(pos_h[1]), 21);
    chk("diag_v", 1, int'(pos_v[1]), 21);
    left = 1; down = 0;
    cyc(1);
    chk("diag_lr_h", 1, int'(pos_h[1]), 21);
    left = 0;
    pulse_reset();
    for (int k = 1; k <= 16; k++) begin
      cyc(1);
      if (k < 8) begin
        chk("wrap_seq", 0, int'(npc_h[0]), s_wrap[k]);
        chk("bounce_seq", 1, int'(npc_h[1]), s_bounce[k]);
        chk("bounce_dir", 1, int'(npc_dir[1]), s_dir[k]);
      end
      chk("div_moved", 2, int'(moved[2]), k % 4 == 0 ? 1 : 0);
    end
    chk("div_h", 2, int'(pos_h[2]), 32);
    cyc(2);
    run = 0;
    for (int k = 0; k < 10; k++) begin
      rand_keys();
      cyc(1);
    end
    run = 1; right = 1; left = 0;
    cyc(3);
    pulse_reset();
    cyc(2);
    repeat (600) begin
      rand_keys();
      run = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 80) == 0) pulse_reset();
      cyc(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
